// File: rtl/barrett4049_rr_sched_if.sv
// Requester/response bundle for the shared mod-4049 Barrett reduction scheduler.
// master = lanes + result consumer, slave = scheduler.
interface barrett4049_rr_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*23-1:0] req_data;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [11:0]           rsp_data;
  logic [TAG_W-1:0]      rsp_tag;
  logic                  busy;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_tag, busy
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_tag, busy
  );
endinterface

// File: rtl/barrett4049_rr_sched.sv
// Round-robin arbiter feeding a 3-stage Barrett reduction pipeline (a mod 4049, mu=4143).
// Define BARRETT_SCHED_STATS_EN to add saturating grant/stall counters.
module barrett4049_rr_sched #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 2
) (
  input  logic clk,
  input  logic rst,
  barrett4049_rr_sched_if.slave bus
`ifdef BARRETT_SCHED_STATS_EN
  ,
  output logic [31:0] stat_grants,
  output logic [31:0] stat_stalls
`endif
);

  localparam logic [22:0] MOD  = 23'd4049;
  localparam logic [22:0] MOD2 = 23'd8098;
  localparam logic [23:0] MU   = 24'd4143;

  logic [TAG_W-1:0] ptr;
  logic [TAG_W-1:0] grant;
  logic [TAG_W-1:0] sel;
  logic             grant_vld;
  logic             adv;
  logic             xfer;
  logic [22:0]      a_in;
  int               idx;

  logic             v1, v2, v3;
  logic [TAG_W-1:0] tag1, tag2, tag3;
  logic [22:0]      a1, a2;
  logic [11:0]      t2;
  logic [11:0]      r3;

  logic [11:0]      t_c;
  logic [22:0]      r0_c;
  logic [22:0]      r_sub;

  // Global stall: nothing moves while an unaccepted result sits at the output.
  assign adv  = !(v3 && !bus.rsp_ready);
  assign xfer = grant_vld && adv && !rst;

  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    sel       = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = TAG_W'(idx);
      if (!grant_vld && bus.req_valid[sel]) begin
        grant_vld = 1'b1;
        grant     = sel;
      end
    end
  end

  always_comb begin
    a_in = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (TAG_W'(k) == grant) a_in = bus.req_data[k*23 +: 23];
    end
  end

  assign bus.req_ready = xfer ? (NUM_REQ'(1) << grant) : '0;

  // Quotient estimate t never exceeds floor(a/4049), so r0 stays in [0, 3*4049).
  assign t_c  = 12'((24'(a1[22:12]) * MU) >> 12);
  assign r0_c = a2 - 23'(t2) * MOD;

  always_comb begin
    if (r0_c >= MOD2)     r_sub = r0_c - MOD2;
    else if (r0_c >= MOD) r_sub = r0_c - MOD;
    else                  r_sub = r0_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr  <= '0;
      v1   <= 1'b0;
      v2   <= 1'b0;
      v3   <= 1'b0;
      tag1 <= '0;
      tag2 <= '0;
      tag3 <= '0;
      a1   <= '0;
      a2   <= '0;
      t2   <= '0;
      r3   <= '0;
    end else if (adv) begin
      v1 <= xfer;
      if (xfer) begin
        a1   <= a_in;
        tag1 <= grant;
        ptr  <= (int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;
      end
      v2 <= v1;
      if (v1) begin
        a2   <= a1;
        t2   <= t_c;
        tag2 <= tag1;
      end
      v3 <= v2;
      if (v2) begin
        r3   <= 12'(r_sub);
        tag3 <= tag2;
      end
    end
  end

  assign bus.rsp_valid = v3;
  assign bus.rsp_data  = r3;
  assign bus.rsp_tag   = tag3;
  assign bus.busy      = v1 | v2 | v3;

`ifdef BARRETT_SCHED_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_grants <= '0;
      stat_stalls <= '0;
    end else begin
      if (xfer && stat_grants != '1) stat_grants <= stat_grants + 32'd1;
      if (v3 && !bus.rsp_ready && stat_stalls != '1) stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_barrett4049_rr_sched.sv
// Directed + scoreboarded bench for barrett4049_rr_sched (NUM_REQ=4).
module tb_barrett4049_rr_sched;
  localparam int NUM_REQ = 4;
  localparam int TAG_W   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  barrett4049_rr_sched_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) bus ();

`ifdef BARRETT_SCHED_STATS_EN
  logic [31:0] stat_grants;
  logic [31:0] stat_stalls;
`endif

  barrett4049_rr_sched #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef BARRETT_SCHED_STATS_EN
    ,
    .stat_grants (stat_grants),
    .stat_stalls (stat_stalls)
`endif
  );

  typedef struct packed {
    logic [1:0]  tag;
    logic [11:0] val;
  } sb_t;

  typedef struct packed {
    logic [22:0] a;
    logic [11:0] expd;
  } vec_t;

  sb_t  sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_push   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int r, input logic [22:0] a);
    bus.req_data[r*23 +: 23] = a;
  endtask

  // Reference model: plain modulo, independent of the Barrett datapath.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
    end else begin
      chk("req_ready_onehot0", 32'($onehot0(bus.req_ready)), 32'd1);
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sbq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected_rsp: got tag %0d data %0d required none", bus.rsp_tag, bus.rsp_data);
        end else begin
          sb_t e;
          e = sbq.pop_front();
          chk("sb_data", 32'(bus.rsp_data), 32'(e.val));
          chk("sb_tag", 32'(bus.rsp_tag), 32'(e.tag));
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          sb_t n;
          n.tag = 2'(i);
          n.val = 12'(bus.req_data[i*23 +: 23] % 23'd4049);
          sbq.push_back(n);
          n_push++;
        end
      end
    end
  end

  initial begin
    vec_t vecs[8];
    int   cnt[NUM_REQ];
    int   nv;
    int   seen;
    int   cyc;
    int   push0;

    vecs[0] = '{a: 23'd0,       expd: 12'd0};
    vecs[1] = '{a: 23'd4048,    expd: 12'd4048};
    vecs[2] = '{a: 23'd4049,    expd: 12'd0};
    vecs[3] = '{a: 23'd8388607, expd: 12'd3128};
    vecs[4] = '{a: 23'd12345,   expd: 12'd198};
    vecs[5] = '{a: 23'd8098,    expd: 12'd0};
    vecs[6] = '{a: 23'd8097,    expd: 12'd4048};
    vecs[7] = '{a: 23'd4050,    expd: 12'd1};
    nv = 8;

    // Reset state, with every requester asking.
    bus.req_valid = '1;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b1;
    #2;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 0);
    chk("rst_rsp_tag", 32'(bus.rsp_tag), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    step();
    step();
    rst = 1'b0;
    #1;

    // Round robin with all four requesters valid for 100 slots.
    for (int i = 0; i < NUM_REQ; i++) cnt[i] = 0;
    for (int s = 0; s < 100; s++) begin
      for (int i = 0; i < NUM_REQ; i++) drive(i, 23'($urandom));
      #1;
      chk("rr_grant", 32'(bus.req_ready), 32'(4'b0001 << (s % 4)));
      for (int i = 0; i < NUM_REQ; i++) cnt[i] += int'(bus.req_ready[i]);
      step();
    end
    bus.req_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) chk("rr_share", 32'(cnt[i]), 25);
    repeat (5) step();
    chk("rr_idle_busy", 32'(bus.busy), 0);

    // Single operand from requester 0.
    bus.req_valid = 4'b0001;
    drive(0, 23'd12345);
    #1;
    chk("single_ready", 32'(bus.req_ready), 32'(4'b0001));
    step();
    bus.req_valid = '0;
    chk("single_e1_valid", 32'(bus.rsp_valid), 0);
    chk("single_e1_busy", 32'(bus.busy), 1);
    step();
    chk("single_e2_valid", 32'(bus.rsp_valid), 0);
    step();
    chk("single_e3_valid", 32'(bus.rsp_valid), 1);
    chk("single_e3_data", 32'(bus.rsp_data), 198);
    chk("single_e3_tag", 32'(bus.rsp_tag), 0);
    chk("single_e3_busy", 32'(bus.busy), 1);
    step();
    chk("single_e4_busy", 32'(bus.busy), 0);
    chk("single_e4_valid", 32'(bus.rsp_valid), 0);

    // Boundary table, back-to-back from requester 1.
    bus.req_valid = 4'b0010;
    drive(1, vecs[0].a);
    #1;
    chk("vec_ready", 32'(bus.req_ready), 32'(4'b0010));
    for (int k = 1; k <= nv + 2; k++) begin
      step();
      if (k < nv) begin
        drive(1, vecs[k].a);
        #1;
        chk("vec_ready", 32'(bus.req_ready), 32'(4'b0010));
      end else begin
        bus.req_valid = '0;
      end
      if (k >= 3) begin
        chk("vec_valid", 32'(bus.rsp_valid), 1);
        chk("vec_data", 32'(bus.rsp_data), 32'(vecs[k-3].expd));
        chk("vec_tag", 32'(bus.rsp_tag), 1);
      end
    end
    step();
    chk("vec_drained", 32'(bus.rsp_valid), 0);

    // Backpressure: three in flight, consumer stalls 5 cycles.
    bus.req_valid = 4'b0100;
    drive(2, 23'd100000);
    step();
    drive(2, 23'd200000);
    step();
    drive(2, 23'd300000);
    step();
    bus.req_valid = 4'b0001;
    bus.rsp_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #1;
      chk("stall_valid", 32'(bus.rsp_valid), 1);
      chk("stall_data", 32'(bus.rsp_data), 2824);
      chk("stall_tag", 32'(bus.rsp_tag), 2);
      chk("stall_req_ready", 32'(bus.req_ready), 0);
      step();
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    chk("drain0_data", 32'(bus.rsp_data), 2824);
    step();
    chk("drain1_valid", 32'(bus.rsp_valid), 1);
    chk("drain1_data", 32'(bus.rsp_data), 1599);
    step();
    chk("drain2_valid", 32'(bus.rsp_valid), 1);
    chk("drain2_data", 32'(bus.rsp_data), 374);
    step();
    chk("drain3_valid", 32'(bus.rsp_valid), 0);
`ifdef BARRETT_SCHED_STATS_EN
    chk("stat_grants", stat_grants, 112);
    chk("stat_stalls", stat_stalls, 5);
`endif

    // Asynchronous reset mid-stream; requester 1 leaves the pointer at 2.
    bus.req_valid = 4'b0010;
    drive(1, 23'd11111);
    step();
    drive(1, 23'd22222);
    step();
    drive(1, 23'd33333);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_req_ready", 32'(bus.req_ready), 0);
    chk("arst_rsp_data", 32'(bus.rsp_data), 0);
    step();
    bus.req_valid = '0;
    step();
    rst = 1'b0;
    bus.req_valid = '1;
    drive(0, 23'd5000);
    #1;
    chk("arst_first_grant", 32'(bus.req_ready), 32'(4'b0001));
    step();
    bus.req_valid = '0;
    seen = 0;
    for (int s = 0; s < 5; s++) begin
      if (bus.rsp_valid) begin
        seen++;
        chk("arst_new_tag", 32'(bus.rsp_tag), 0);
        chk("arst_new_data", 32'(bus.rsp_data), 951);
      end
      step();
    end
    chk("arst_rsp_count", 32'(seen), 1);

    // Random traffic with random backpressure; checked by the scoreboard.
    push0 = n_push;
    cyc   = 0;
    while ((n_push - push0) < 10000 && cyc < 60000) begin
      bus.req_valid = 4'($urandom);
      for (int i = 0; i < NUM_REQ; i++) drive(i, 23'($urandom));
      bus.rsp_ready = ($urandom_range(3) != 0);
      step();
      cyc++;
    end
    chk("rand_transfers", 32'((n_push - push0) >= 10000), 1);
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (6) step();
    chk("rand_sb_empty", 32'(sbq.size()), 0);
    chk("rand_busy", 32'(bus.busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
